// File: rtl/alu4_pkg.sv
// Shared constants and command record for the alu_4bit issue stage.
// ALU4_TAG_EN adds a 4-bit tag field to the command record.
package alu4_pkg;

  localparam int DW   = 4;
  localparam int OPW  = 2;
  localparam int TAGW = 4;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
`ifdef ALU4_TAG_EN
    logic [TAGW-1:0] tag;
`endif
  } cmd_t;

endpackage

// File: rtl/alu4_cmd_fifo.sv
// DEPTH-entry synchronous FIFO of cmd_t with a show-ahead head output.
// Full/empty come from read/write pointers carrying one extra wrap bit.
module alu4_cmd_fifo
  import alu4_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  cmd_t                       din,
  input  logic                       pop,
  output cmd_t                       dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu4_issue_stage.sv
// Command FIFO + issue register + result register around a combinational alu_4bit.
// Optional ALU4_TAG_EN carries a per-command tag from cmd_tag through to res_tag.
module alu4_issue_stage
  import alu4_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = alu4_pkg::DW,
  parameter int OPW   = alu4_pkg::OPW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [OPW-1:0]             cmd_op,
  input  logic [DW-1:0]              cmd_a,
  input  logic [DW-1:0]              cmd_b,
`ifdef ALU4_TAG_EN
  input  logic [TAGW-1:0]            cmd_tag,
  output logic [TAGW-1:0]            res_tag,
`endif
  output logic [OPW-1:0]             alu_op,
  output logic [DW-1:0]              alu_a,
  output logic [DW-1:0]              alu_b,
  input  logic [DW-1:0]              alu_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DW-1:0]              res_data,
  output logic [OPW-1:0]             res_op,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  cmd_t           push_cmd, head_cmd;
  cmd_t           iss_q, iss_d;
  logic           iss_v_q, iss_v_d;
  logic           res_valid_q, res_valid_d;
  logic [DW-1:0]  res_data_q, res_data_d;
  logic [OPW-1:0] res_op_q, res_op_d;
`ifdef ALU4_TAG_EN
  logic [TAGW-1:0] res_tag_q, res_tag_d;
`endif
  logic           full, empty, push, pop, advance;

  alu4_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (head_cmd),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    push_cmd    = '0;
    push_cmd.op = cmd_op;
    push_cmd.a  = cmd_a;
    push_cmd.b  = cmd_b;
`ifdef ALU4_TAG_EN
    push_cmd.tag = cmd_tag;
`endif

    push    = cmd_valid && !full;
    advance = iss_v_q && (!res_valid_q || res_ready);
    pop     = !empty && (!iss_v_q || advance);

    // An emptied slot keeps its operands so the ALU inputs do not toggle while idle.
    iss_v_d = iss_v_q;
    iss_d   = iss_q;
    if (pop) begin
      iss_v_d = 1'b1;
      iss_d   = head_cmd;
    end else if (advance) begin
      iss_v_d = 1'b0;
    end

    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
`ifdef ALU4_TAG_EN
    res_tag_d   = res_tag_q;
`endif
    if (advance) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_out;
      res_op_d    = iss_q.op;
`ifdef ALU4_TAG_EN
      res_tag_d   = iss_q.tag;
`endif
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_v_q     <= 1'b0;
      iss_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
`ifdef ALU4_TAG_EN
      res_tag_q   <= '0;
`endif
    end else begin
      iss_v_q     <= iss_v_d;
      iss_q       <= iss_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
`ifdef ALU4_TAG_EN
      res_tag_q   <= res_tag_d;
`endif
    end
  end

  assign cmd_ready = !full;
  assign alu_op    = iss_q.op;
  assign alu_a     = iss_q.a;
  assign alu_b     = iss_q.b;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
`ifdef ALU4_TAG_EN
  assign res_tag   = res_tag_q;
`endif

endmodule

// File: tb/tb_alu4_issue_stage.sv
// Self-checking bench for alu4_issue_stage with a behavioural alu_4bit
// (00 add, 01 sub, 10 and, 11 or) closing the loop; tag checks under ALU4_TAG_EN.
module tb_alu4_issue_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [3:0] cmd_tag = '0;
  logic [3:0] res_tag_w;
  logic [1:0] alu_op;
  logic [3:0] alu_a, alu_b, alu_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic [1:0] res_op;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [1:0] op; logic [3:0] a; logic [3:0] b; logic [3:0] exp; } vec_t;
  typedef struct { logic [1:0] op; logic [3:0] data; logic [3:0] tag; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_op, alu_a, alu_b);

  alu4_issue_stage #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
`ifdef ALU4_TAG_EN
    .cmd_tag    (cmd_tag),
    .res_tag    (res_tag_w),
`endif
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_op     (res_op),
    .fifo_count (fifo_count)
  );
`ifndef ALU4_TAG_EN
  assign res_tag_w = '0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result monitor: a handshake visible at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got data %0h with empty scoreboard", res_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", res_data, e.data);
        check("res_op", res_op, e.op);
`ifdef ALU4_TAG_EN
        check("res_tag", res_tag_w, e.tag);
`endif
      end
    end
  end

  // Called at posedge+1; offers one command for one cycle, returns at the next posedge+1.
  task automatic drive_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] tag, input logic [3:0] exp, output bit acc);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    @(negedge clk);
    acc = cmd_ready;
    if (acc) begin
      e.op = op; e.data = exp; e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int cyc = 0;
    res_ready = 1'b1;
    while ((sb.size() != 0 || res_valid) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_scoreboard_empty", sb.size(), 0);
    check("drain_fifo_empty", fifo_count, 0);
  endtask

  vec_t vecs[8];

  initial begin
    bit acc;
    int n_acc;
    logic [1:0] hold_op;
    logic [3:0] hold_a, hold_b;

    vecs[0] = '{2'b00, 4'h5, 4'h3, 4'h8};
    vecs[1] = '{2'b01, 4'h5, 4'h3, 4'h2};
    vecs[2] = '{2'b10, 4'h5, 4'h3, 4'h1};
    vecs[3] = '{2'b11, 4'h5, 4'h3, 4'h7};
    vecs[4] = '{2'b00, 4'hF, 4'h1, 4'h0};
    vecs[5] = '{2'b01, 4'h3, 4'h5, 4'hE};
    vecs[6] = '{2'b10, 4'hC, 4'hA, 4'h8};
    vecs[7] = '{2'b11, 4'hC, 4'hA, 4'hE};

    // Power-on reset values
    #2;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_op", res_op, 0);
    check("rst_alu_bus", {alu_op, alu_a, alu_b}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(1);

    // Single command latency: accepted at edge N, on alu_* after N+1, res_valid after N+2
    res_ready = 1'b1;
    drive_cmd(2'b00, 4'h5, 4'h3, 4'h0, 4'h8, acc);
    check("single_accept", acc, 1);
    check("single_valid_n", res_valid, 0);
    cycles(1);
    check("single_alu_bus", {alu_op, alu_a, alu_b}, {2'b00, 4'h5, 4'h3});
    check("single_valid_n1", res_valid, 0);
    cycles(1);
    check("single_valid_n2", res_valid, 1);
    drain();

    // Table-driven back-to-back stream; results must appear on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      drive_cmd(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), vecs[i].exp, acc);
      check("stream_accept", acc, 1);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stream_consecutive", res_valid, 1);
    end
    @(negedge clk);
    check("stream_done", res_valid, 0);
    @(posedge clk); #1;
    drain();

    // Backpressure: result slot + issue slot + 4 FIFO entries, then cmd_ready drops
    res_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 7; i++) begin
      drive_cmd(2'(i), 4'(i + 1), 4'(2 * i + 1), 4'(i), alu_ref(2'(i), 4'(i + 1), 4'(2 * i + 1)), acc);
      n_acc += int'(acc);
    end
    check("bp_accepted", n_acc, 6);
    check("bp_cmd_ready", cmd_ready, 0);
    check("bp_fifo_count", fifo_count, 4);
    check("bp_res_valid", res_valid, 1);
    hold_op = alu_op; hold_a = alu_a; hold_b = alu_b;
    cycles(3);
    check("bp_alu_stable", {alu_op, alu_a, alu_b}, {hold_op, hold_a, hold_b});
    check("bp_alu_is_second_cmd", {alu_op, alu_a, alu_b}, {2'd1, 4'd2, 4'd3});
    drain();

    // Simultaneous push and pop at occupancy 2
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      drive_cmd(2'b01, 4'(8 + i), 4'(i), 4'(i), alu_ref(2'b01, 4'(8 + i), 4'(i)), acc);
    check("pp_count_before", fifo_count, 2);
    res_ready = 1'b1;
    drive_cmd(2'b11, 4'h9, 4'h6, 4'h4, 4'hF, acc);
    check("pp_accept", acc, 1);
    check("pp_count_after", fifo_count, 2);
    drain();

    // Tags 1,2,3 with interleaved result stalls
    for (int i = 1; i <= 3; i++) begin
      res_ready = i[0];
      drive_cmd(2'(i), 4'(3 * i), 4'(i), 4'(i), alu_ref(2'(i), 4'(3 * i), 4'(i)), acc);
    end
    for (int c = 0; c < 40 && (sb.size() != 0 || res_valid); c++) begin
      res_ready = 1'($urandom_range(0, 1));
      cycles(1);
    end
    drain();

    // Reset mid-operation discards buffered commands and the pending result
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      drive_cmd(2'b10, 4'hF, 4'(i), 4'(i), alu_ref(2'b10, 4'hF, 4'(i)), acc);
    rst = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_fifo_count", fifo_count, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_alu_bus", {alu_op, alu_a, alu_b}, 0);
    check("mid_rst_res_data", {res_data, res_op}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    cycles(3);
    check("post_rst_no_result", res_valid, 0);
    check("post_rst_count", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
